// File: rtl/io_bus_responder.sv
// Memory-mapped I/O responder: GPIO out/in, optional timer+compare (IO_TIMER_EN), byte TX FIFO.
// Latency: reads combinational; writes commit at the rising edge; pushed byte is valid one edge later.
// Backpressure: TX FIFO holds its head while tx_ready is low; a push into a full FIFO is dropped and flags overflow.
module io_bus_responder #(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0400,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] io_address,
   input  logic [31:0] io_write_value,
   output logic [31:0] io_read_value,
   input  logic        io_write_en,
   input  logic        io_read_en,
   input  logic [7:0]  gpio_in,
   output logic [7:0]  gpio_out,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        irq
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   logic          sel;
   logic [2:0]    idx;
   logic          wr;
   logic          push_req;
   logic          push_ok;
   logic          pop;
   logic          full;
   logic          empty;
   logic          overflow;
   logic [7:0]    gpio_meta;
   logic [7:0]    gpio_sync;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [31:0]   timer;
   logic [31:0]   compare;
   logic          match;

   // Address bits [1:0] and the upper store bits carry no meaning here
   logic unused_bits;
   assign unused_bits = &{1'b0, io_address[1:0], io_write_value[31:8]};

   assign sel      = (io_address[31:5] == BASE_ADDR[31:5]);
   assign idx      = io_address[4:2];
   assign wr       = io_write_en && sel;
   assign full     = (count == FULL_CNT);
   assign empty    = (count == '0);
   assign pop      = !empty && tx_ready;
   assign push_req = wr && (idx == 3'd5);
   // A pop in the same cycle frees a slot, so a push into a full FIFO still lands
   assign push_ok  = push_req && (!full || pop);

   assign tx_valid = !empty;
   assign tx_data  = empty ? 8'h00 : mem[rd_ptr];
   assign irq      = match;

   // Two-flop synchroniser for the asynchronous input pins
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gpio_meta <= '0;
         gpio_sync <= '0;
      end else begin
         gpio_meta <= gpio_in;
         gpio_sync <= gpio_meta;
      end
   end

   // Output port register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         gpio_out <= '0;
      else if (wr && idx == 3'd0)
         gpio_out <= io_write_value[7:0];
   end

   // FIFO pointers, occupancy and sticky overflow (set wins over W1C)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         if (push_ok && !pop)
            count <= count + CW'(1);
         else if (!push_ok && pop)
            count <= count - CW'(1);
         if (push_req && !push_ok)
            overflow <= 1'b1;
         else if (wr && idx == 3'd4 && io_write_value[3])
            overflow <= 1'b0;
      end
   end

   // FIFO storage; no reset needed because tx_data is masked while empty
   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= io_write_value[7:0];
   end

`ifdef IO_TIMER_EN
   // Free-running timer with load, compare register, and sticky match (set wins over W1C)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timer   <= '0;
         compare <= 32'hFFFF_FFFF;
         match   <= 1'b0;
      end else begin
         if (wr && idx == 3'd2)
            timer <= io_write_value;
         else
            timer <= timer + 32'd1;
         if (wr && idx == 3'd3)
            compare <= io_write_value;
         if (timer == compare)
            match <= 1'b1;
         else if (wr && idx == 3'd4 && io_write_value[0])
            match <= 1'b0;
      end
   end
`else
   assign timer   = '0;
   assign compare = '0;
   assign match   = 1'b0;
`endif

   // Combinational read mux; reads have no side effects
   always_comb begin
      io_read_value = '0;
      if (io_read_en && sel) begin
         case (idx)
            3'd0:    io_read_value = {24'h0, gpio_out};
            3'd1:    io_read_value = {24'h0, gpio_sync};
            3'd2:    io_read_value = timer;
            3'd3:    io_read_value = compare;
            3'd4:    io_read_value = {28'h0, overflow, empty, full, match};
            default: io_read_value = '0;
         endcase
      end
   end
endmodule

// File: tb/tb_io_bus_responder.sv
// Self-checking bench for io_bus_responder: queue-based reference model plus scoreboard monitors.
// Reads and TX bytes are predicted at issue time and checked by a negedge monitor.
// Directed scenarios first, then a randomized phase with random tx_ready backpressure.
`timescale 1ns/1ps
module tb_io_bus_responder;
   localparam logic [31:0] BASE  = 32'h0000_0400;
   localparam int          DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] io_address;
   logic [31:0] io_write_value;
   logic [31:0] io_read_value;
   logic        io_write_en;
   logic        io_read_en;
   logic [7:0]  gpio_in;
   logic [7:0]  gpio_out;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        irq;

   always #5 clk = ~clk;

   io_bus_responder #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .io_address(io_address), .io_write_value(io_write_value),
      .io_read_value(io_read_value), .io_write_en(io_write_en), .io_read_en(io_read_en),
      .gpio_in(gpio_in), .gpio_out(gpio_out), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .irq(irq)
   );

   int compared   = 0;
   int mismatched = 0;

   // Scoreboard queues and reference model state
   logic [31:0] rd_q[$];
   logic [7:0]  sb_tx[$];
   logic [7:0]  mq[$];
   logic [7:0]  m_gpio_out, m_s1, m_s2;
   logic [31:0] m_timer, m_compare;
   logic        m_match, m_ovf;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] a);
      logic [31:0] v;
      v = 32'h0;
      if (a[31:5] == BASE[31:5]) begin
         case (a[4:2])
            3'd0: v = {24'h0, m_gpio_out};
            3'd1: v = {24'h0, m_s2};
`ifdef IO_TIMER_EN
            3'd2: v = m_timer;
            3'd3: v = m_compare;
`endif
            3'd4: v = {28'h0, m_ovf, mq.size() == 0, mq.size() == DEPTH, m_match};
            default: v = 32'h0;
         endcase
      end
      return v;
   endfunction

   // Reference model: advances on each edge from the pre-edge bus inputs
   always @(posedge clk or posedge reset) begin : mdl
      logic       in_win, w, full, pop;
      logic [2:0] ix;
      logic       hit;
      if (reset) begin
         m_gpio_out = 8'h0; m_s1 = 8'h0; m_s2 = 8'h0;
         m_timer = 32'h0; m_compare = 32'hFFFF_FFFF; m_match = 1'b0; m_ovf = 1'b0;
         mq.delete();
         sb_tx.delete();
      end else begin
         in_win = (io_address[31:5] == BASE[31:5]);
         ix     = io_address[4:2];
         w      = io_write_en && in_win;
         full   = (mq.size() == DEPTH);
         pop    = (mq.size() != 0) && tx_ready;
         hit    = (m_timer == m_compare);
         if (pop) void'(mq.pop_front());
         if (w && ix == 3'd5) begin
            if (!full || pop) begin
               mq.push_back(io_write_value[7:0]);
               sb_tx.push_back(io_write_value[7:0]);
            end else begin
               m_ovf = 1'b1;
            end
         end else if (w && ix == 3'd4 && io_write_value[3]) begin
            m_ovf = 1'b0;
         end
         if (w && ix == 3'd0) m_gpio_out = io_write_value[7:0];
         m_s2 = m_s1;
         m_s1 = gpio_in;
`ifdef IO_TIMER_EN
         if (w && ix == 3'd2) m_timer = io_write_value;
         else m_timer = m_timer + 32'd1;
         if (w && ix == 3'd3) m_compare = io_write_value;
         if (hit) m_match = 1'b1;
         else if (w && ix == 3'd4 && io_write_value[0]) m_match = 1'b0;
`else
         hit = hit & 1'b0;
`endif
      end
   end

   // Monitor: checks whatever the DUT presents, decoupled from stimulus
   always @(negedge clk) begin
      if (!reset) begin
         if (io_read_en) begin
            if (rd_q.size() == 0) begin
               compared++; mismatched++;
               $display("FAIL rd_q: read seen with no expected value queued at %0t", $time);
            end else begin
               chk("read_value", io_read_value, rd_q.pop_front());
            end
         end
         chk("tx_valid", {31'h0, tx_valid}, {31'h0, mq.size() != 0});
         if (tx_valid && tx_ready) begin
            if (sb_tx.size() == 0) begin
               compared++; mismatched++;
               $display("FAIL tx_byte: got %h with nothing expected at %0t", tx_data, $time);
            end else begin
               chk("tx_byte", {24'h0, tx_data}, {24'h0, sb_tx.pop_front()});
            end
         end
         chk("gpio_out", {24'h0, gpio_out}, {24'h0, m_gpio_out});
         chk("irq", {31'h0, irq}, {31'h0, m_match});
      end
   end

   task automatic step(input logic we, input logic re, input logic [31:0] addr, input logic [31:0] wdata);
      io_write_en    = we;
      io_read_en     = re;
      io_address     = addr;
      io_write_value = wdata;
      if (re) rd_q.push_back(model_read(addr));
      @(posedge clk);
      #1;
      io_write_en = 1'b0;
      io_read_en  = 1'b0;
   endtask

   task automatic drain();
      tx_ready = 1'b1;
      for (int k = 0; k < 40 && mq.size() != 0; k++) step(0, 0, 32'h0, 32'h0);
      step(0, 0, 32'h0, 32'h0);
      chk("drain_valid", {31'h0, tx_valid}, 32'h0);
      chk("drain_sb", sb_tx.size(), 32'h0);
   endtask

   initial begin
      logic        exp_irq;
      logic [31:0] a, wd;
      int unsigned ix, r;
      reset = 1'b1; io_address = '0; io_write_value = '0; io_write_en = 0; io_read_en = 0;
      gpio_in = 8'h0; tx_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_gpio_out", {24'h0, gpio_out}, 32'h0);
      chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
      chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
      chk("rst_irq", {31'h0, irq}, 32'h0);
      reset = 1'b0;

      // Read all eight registers after reset
      for (int i = 0; i < 8; i++) step(0, 1, BASE + 32'(i * 4), 32'h0);

      // GPIO out, out-of-window write and read
      step(1, 0, BASE, 32'h1A5);
      chk("gpio_a5", {24'h0, gpio_out}, 32'hA5);
      step(1, 0, BASE + 32, 32'h3C);
      chk("gpio_oow", {24'h0, gpio_out}, 32'hA5);
      step(0, 1, BASE + 32, 32'h0);
      gpio_in = 8'h5A;
      repeat (3) step(0, 0, 32'h0, 32'h0);
      step(0, 1, BASE + 4, 32'h0);

      // Timer compare match 4 edges after loading TIMER, then W1C
      step(1, 0, BASE + 12, 32'd13);
      step(1, 0, BASE + 8, 32'd10);
      repeat (3) step(0, 0, 32'h0, 32'h0);
      chk("irq_early", {31'h0, irq}, 32'h0);
      step(0, 0, 32'h0, 32'h0);
`ifdef IO_TIMER_EN
      exp_irq = 1'b1;
`else
      exp_irq = 1'b0;
`endif
      chk("irq_match", {31'h0, irq}, {31'h0, exp_irq});
      step(0, 1, BASE + 16, 32'h0);
      step(1, 0, BASE + 16, 32'h1);
      chk("irq_cleared", {31'h0, irq}, 32'h0);

      // Overflow: five pushes into a depth-4 FIFO with the consumer stalled
      tx_ready = 1'b0;
      for (int i = 1; i <= 5; i++) step(1, 0, BASE + 20, 32'(i));
      step(0, 1, BASE + 16, 32'h0);
      chk("ovf_head", {24'h0, tx_data}, 32'h1);
      step(0, 1, BASE + 20, 32'h0);
      step(1, 0, BASE + 16, 32'h8);
      drain();
      step(0, 1, BASE + 16, 32'h0);

      // Push into a full FIFO while popping: accepted, no overflow
      for (int i = 0; i < 4; i++) step(1, 0, BASE + 20, 32'h10 + 32'(i));
      tx_ready = 1'b1;
      step(1, 0, BASE + 20, 32'h14);
      tx_ready = 1'b0;
      step(0, 1, BASE + 16, 32'h0);
      drain();

      // Async reset mid-drain with bytes queued
      tx_ready = 1'b0;
      for (int i = 0; i < 3; i++) step(1, 0, BASE + 20, 32'h20 + 32'(i));
      tx_ready = 1'b1;
      step(0, 0, 32'h0, 32'h0);
      reset = 1'b1;
      #1;
      chk("async_rst_valid", {31'h0, tx_valid}, 32'h0);
      tx_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      step(0, 0, 32'h0, 32'h0);
      chk("post_rst_valid", {31'h0, tx_valid}, 32'h0);
      step(0, 1, BASE + 16, 32'h0);

      // Randomized phase
      for (int n = 0; n < 500; n++) begin
         ix = $urandom_range(0, 7);
         r  = $urandom_range(0, 99);
         if (r < 10)      a = BASE + 32 + ix * 4;
         else if (r < 45) a = BASE + 20;
         else             a = BASE + ix * 4 + $urandom_range(0, 3);
         wd = $urandom;
         if (a[4:2] == 3'd4 && $urandom_range(0, 3) != 0) wd = 32'h0;
         tx_ready = ($urandom_range(0, 2) == 0);
         gpio_in  = 8'($urandom);
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, wd);
      end
      drain();
      step(0, 0, 32'h0, 32'h0);
      chk("rd_q_empty", rd_q.size(), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/io_bus_responder.md
# io_bus_responder

Memory-mapped I/O responder on the `Risc32` core's single-cycle `io_*` bus, i.e. the target side of the processor's load/store I/O port. It decodes a 32-byte window and holds an 8-bit output port, a synchronised 8-bit input port, an optional 32-bit timer with compare flag, and a byte TX FIFO. The FIFO drains to an external consumer over a valid/ready handshake. Reads are combinational, so they fit the core's single-cycle load. Writes commit on the rising clock edge.

## Interface
- `BASE_ADDR`, 32'h0000_0400: window base, 32-byte aligned; selected when `io_address[31:5] == BASE_ADDR[31:5]`.
- `FIFO_DEPTH`, 4: TX FIFO entries; power of two, 2..16.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `io_address`  in  32  byte address from core; register index = `io_address[4:2]`, bits [1:0] ignored.
- `io_write_value`  in  32  store data.
- `io_read_value`  out  32  load data; combinational.
- `io_write_en`  in  1  store strobe, sampled at edge.
- `io_read_en`  in  1  load strobe.
- `gpio_in`  in  8  asynchronous input pins.
- `gpio_out`  out  8  output port register.
- `tx_data`  out  8  FIFO head byte.
- `tx_valid`  out  1  FIFO non-empty.
- `tx_ready`  in  1  consumer accepts `tx_data` at edge when `tx_valid`.
- `irq`  out  1  equals STATUS.match.

## Operation
- Register map by index:
  - 0 GPIO_OUT: R/W, bits [7:0].
  - 1 GPIO_IN: RO, two-flop-synchronised `gpio_in`.
  - 2 TIMER: R/W, 32-bit.
  - 3 COMPARE: R/W, 32-bit.
  - 4 STATUS: bit0 match (W1C), bit1 full, bit2 empty, bit3 overflow (W1C); other bits read 0.
  - 5 TXDATA: write pushes `io_write_value[7:0]`; reads 0.
  - 6, 7: read 0; writes ignored.
- `io_read_value` is 0 when `io_read_en`=0 or the address is outside the window. Reads have no side effects.
- Writes outside the window are ignored. Unused upper write bits are ignored.
- TIMER:
  - Increments by 1 every cycle, wrapping 32'hFFFF_FFFF → 0.
  - A write loads `io_write_value`, overriding that cycle's increment.
- Match: set on the edge after any cycle where TIMER == COMPARE. Set has priority over a same-cycle W1C.
- FIFO push: a write to TXDATA when not full stores the byte. A push when full drops the byte and sets overflow.
- FIFO pop: occurs when `tx_valid && tx_ready`.
- Simultaneous push and pop when full: the pop frees the slot, the push is accepted, count is unchanged, and no overflow is flagged. When empty, a push alone is accepted; a pop cannot occur.
- `tx_data` is the head entry and stays stable while `tx_valid && !tx_ready`.
- Read and write in the same cycle: the read returns the pre-edge value.

## Timing
- Reset values: `gpio_out`=0, synchroniser=0, TIMER=0, COMPARE=32'hFFFF_FFFF, match=0, overflow=0, FIFO empty (`tx_valid`=0, `tx_data`=0), `irq`=0.
- Reset asserted mid-operation clears all state immediately (async), including queued bytes.
- Write latency: visible to a read in the following cycle.
- GPIO_IN latency: 2 edges from pin change to readable value.
- FIFO latency: a pushed byte reaches `tx_valid` on the edge after the store.
- Pointers are log2(FIFO_DEPTH) bits with a separate count of log2(FIFO_DEPTH)+1 bits; full = count == FIFO_DEPTH.

## Configuration
- `IO_TIMER_EN` defined: TIMER, COMPARE, match and `irq` behave as above.
- Not defined:
  - No timer logic is built.
  - TIMER and COMPARE read 0 and ignore writes.
  - STATUS.match and `irq` are tied 0.
  - All other behaviour is unchanged.

## Test plan
- Reset, then read all 8 indices → 0, 0, 0 (+1 per elapsed cycle with timer), 32'hFFFF_FFFF, 32'h4, 0, 0, 0.
- Write 32'h1A5 to BASE+0 → `gpio_out`=8'hA5; write to BASE+32 → no change, and reading BASE+32 returns 0.
- Write TIMER=10, COMPARE=13 → match and `irq` rise 4 edges after the write; W1C to STATUS clears them; with `IO_TIMER_EN` undefined, both stay 0.
- `tx_ready`=0, push 5 bytes at depth 4 → bytes 1-4 held, full=1, overflow=1; raise `tx_ready` → 1,2,3,4 delivered in order, then empty=1.
- Full FIFO with a push and `tx_ready`=1 in the same cycle → count stays 4, overflow stays 0, the new byte is delivered last.
- Assert `reset` mid-drain with 3 bytes queued → `tx_valid`=0 immediately; FIFO empty after release.
